// File: rtl/aes_round_ctrl.sv
// AES-128 encryption round sequencer.
// Owns the state and round-key registers and walks them through the initial
// AddRoundKey, nine full rounds and the final round (11 cycles after accept).
// Optional feature macro: AES_RND_CTRL_ABORT_EN -- when defined, a load while
// busy aborts the current run and restarts with the new key/plaintext.
// Byte 0 sits in [127:120]; bytes are column-major (byte r+4c is row r, col c).

module aes_round_ctrl (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [127:0] key,
   input  logic [127:0] plaintext,
   output logic [127:0] cyphertext,
   output logic         done,
   output logic         busy
);

   typedef enum logic [2:0] {StIdle, StInit, StRound, StFinal, StDone} fsm_e;

   fsm_e         fsm_q;
   logic [127:0] state_q;
   logic [127:0] rk_q;
   logic [3:0]   round_q;
   logic [7:0]   rcon_q;
   logic [127:0] cyphertext_q;
   logic         done_q;
   logic         busy_q;

   // ---------------------------------------------------------------------
   // GF(2^8) helpers
   // ---------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box computed as multiplicative inverse (x^254) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      x252 = gf_mul(x240, x12);
      inv  = gf_mul(x252, x2);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // ---------------------------------------------------------------------
   // Round datapath
   // ---------------------------------------------------------------------
   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   // Row r of the output takes column (c+r) mod 4 of the input.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   // One step of the AES-128 key schedule: produces the next round key.
   function automatic logic [127:0] key_expand_step(input logic [127:0] k,
                                                    input logic [7:0]   rc);
      logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
      w0 = k[127:96];
      w1 = k[95:64];
      w2 = k[63:32];
      w3 = k[31:0];
      t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   logic [127:0] sr_out;
   logic [127:0] round_out;
   logic [127:0] final_out;
   logic [127:0] rk_next;
   logic [7:0]   rcon_next;
   logic         accept;

   // Combinational round datapath shared by ROUND and FINAL.
   always_comb begin
      sr_out    = shift_rows(sub_bytes(state_q));
      round_out = mix_columns(sr_out) ^ rk_q;
      final_out = sr_out ^ rk_q;
      rk_next   = key_expand_step(rk_q, rcon_q);
      rcon_next = xtime(rcon_q);
   end

   // Start condition: idle/done only, or any state when aborting is enabled.
   always_comb begin
`ifdef AES_RND_CTRL_ABORT_EN
      accept = load;
`else
      accept = load && ((fsm_q == StIdle) || (fsm_q == StDone));
`endif
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm_q        <= StIdle;
         state_q      <= '0;
         rk_q         <= '0;
         round_q      <= '0;
         rcon_q       <= '0;
         cyphertext_q <= '0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else if (accept) begin
         state_q <= plaintext;
         rk_q    <= key;
         round_q <= 4'd1;
         rcon_q  <= 8'h01;
         done_q  <= 1'b0;
         busy_q  <= 1'b1;
         fsm_q   <= StInit;
      end else begin
         case (fsm_q)
            StIdle, StDone: ;
            StInit: begin
               state_q <= state_q ^ rk_q;
               rk_q    <= rk_next;
               rcon_q  <= rcon_next;
               fsm_q   <= StRound;
            end
            StRound: begin
               state_q <= round_out;
               rk_q    <= rk_next;
               rcon_q  <= rcon_next;
               round_q <= round_q + 4'd1;
               if (round_q == 4'd9) fsm_q <= StFinal;
            end
            StFinal: begin
               state_q      <= final_out;
               cyphertext_q <= final_out;
               done_q       <= 1'b1;
               busy_q       <= 1'b0;
               fsm_q        <= StDone;
            end
            default: fsm_q <= StIdle;
         endcase
      end
   end

   assign cyphertext = cyphertext_q;
   assign done       = done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed self-checking bench for aes_round_ctrl (FIPS-197 vectors).
// Honours AES_RND_CTRL_ABORT_EN for the load-while-busy scenario.

module tb_aes_round_ctrl;

   logic         clk;
   logic         reset;
   logic         load;
   logic [127:0] key;
   logic [127:0] plaintext;
   logic [127:0] cyphertext;
   logic         done;
   logic         busy;

   int checks;
   int errors;
   int cyc;
   int busy_cnt;

   localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic [7:0] rcon_exp [10];

   aes_round_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .key        (key),
      .plaintext  (plaintext),
      .cyphertext (cyphertext),
      .done       (done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after a clock edge; leaves the bench #1 after the accept edge E0.
   task automatic start(input logic [127:0] k, input logic [127:0] p);
      load      = 1'b1;
      key       = k;
      plaintext = p;
      @(posedge clk);
      #1;
      load     = 1'b0;
      cyc      = 0;
      busy_cnt = (busy === 1'b1) ? 1 : 0;
   endtask

   // Advance until done is seen, bounded; cyc counts edges since E0.
   task automatic wait_done();
      while (done !== 1'b1 && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
         if (busy === 1'b1) busy_cnt++;
      end
   endtask

   initial begin
      int pulses;
      int wide;
      logic prev_done;
      checks    = 0;
      errors    = 0;
      rcon_exp  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      reset     = 1'b0;
      load      = 1'b0;
      key       = '0;
      plaintext = '0;

      // Reset state
      #2;
      check("reset_ct", cyphertext, 128'h0);
      check("reset_done", 128'(done), 128'h0);
      check("reset_busy", 128'(busy), 128'h0);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      // FIPS-197 C.1, single-cycle load
      start(C1Key, C1Pt);
      check("c1_busy_after_e0", 128'(busy), 128'h1);
      wait_done();
      check("c1_latency", 128'(cyc), 128'd11);
      check("c1_busy_cycles", 128'(busy_cnt), 128'd11);
      check("c1_ct", cyphertext, C1Ct);
      check("c1_busy_low", 128'(busy), 128'h0);
      @(posedge clk);
      #1;
      check("c1_done_held", 128'(done), 128'h1);
      check("c1_ct_held", cyphertext, C1Ct);

      // FIPS-197 Appendix B with rcon sequence
      start(BKey, BPt);
      check("b_done_drop", 128'(done), 128'h0);
      check("b_ct_kept", cyphertext, C1Ct);
      check("b_rcon0", 128'(dut.rcon_q), 128'(rcon_exp[0]));
      for (int k = 1; k < 10; k++) begin
         @(posedge clk);
         #1;
         cyc++;
         check($sformatf("b_rcon%0d", k), 128'(dut.rcon_q), 128'(rcon_exp[k]));
      end
      wait_done();
      check("b_latency", 128'(cyc), 128'd11);
      check("b_ct", cyphertext, BCt);

      // Inputs change the cycle after accept
      start(C1Key, C1Pt);
      key       = BKey;
      plaintext = BPt;
      wait_done();
      check("chg_latency", 128'(cyc), 128'd11);
      check("chg_ct", cyphertext, C1Ct);

      // Load while busy at round 5
      start(C1Key, C1Pt);
      repeat (5) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("lb_round5", 128'(dut.round_q), 128'd5);
      load      = 1'b1;
      key       = BKey;
      plaintext = BPt;
      @(posedge clk);
      #1;
      cyc++;
      load = 1'b0;
      check("lb_busy", 128'(busy), 128'h1);
      wait_done();
`ifdef AES_RND_CTRL_ABORT_EN
      check("lb_latency", 128'(cyc), 128'd17);
      check("lb_ct", cyphertext, BCt);
`else
      check("lb_latency", 128'(cyc), 128'd11);
      check("lb_ct", cyphertext, C1Ct);
`endif
      @(posedge clk);
      #1;
      check("lb_done_held", 128'(done), 128'h1);

      // Asynchronous reset mid-run at round 6
      start(C1Key, C1Pt);
      repeat (6) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("ar_done", 128'(done), 128'h0);
      check("ar_busy", 128'(busy), 128'h0);
      check("ar_ct", cyphertext, 128'h0);
      check("ar_round", 128'(dut.round_q), 128'h0);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("ar_idle_done", 128'(done), 128'h0);
      start(C1Key, C1Pt);
      wait_done();
      check("ar_rerun_latency", 128'(cyc), 128'd11);
      check("ar_rerun_ct", cyphertext, C1Ct);

      // Back-to-back with load held high
      load      = 1'b1;
      key       = C1Key;
      plaintext = C1Pt;
      @(posedge clk);
      #1;
      check("bb_accept_done_low", 128'(done), 128'h0);
      pulses    = 0;
      wide      = 0;
      prev_done = 1'b0;
      for (int i = 1; i <= 36; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            pulses++;
            if (prev_done === 1'b1) wide++;
            check($sformatf("bb_ct_pulse%0d", pulses), cyphertext, C1Ct);
         end
         prev_done = done;
      end
      load = 1'b0;
      check("bb_pulses", 128'(pulses), 128'd3);
      check("bb_pulse_width", 128'(wide), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
